// File: rtl/ad9866_cmd_arb.sv
// Purpose : arbitrates host and local command requests onto the single AD9866 control port,
//           with one pending slot per requester, ack timeout and an inter-command recovery gap.
// Latency : host_rqst in cycle N (block idle, nothing pending) -> out_rqst in cycle N+2.
// Backpressure: local side is valid/ready (loc_ready = slot empty); host side has no
//           backpressure, a newer host command overwrites a pending one and raises host_ovf.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   host_addr/data/rqst      host command, rqst is a single-cycle pulse
//   loc_addr/data/valid/ready local requester, transfer on loc_valid & loc_ready
//   out_addr/data/rqst       command to ad9866ctrl, rqst is a single-cycle strobe
//   in_ack                   single-cycle completion pulse from ad9866ctrl
//   clr_status               pulse, clears the sticky flags
//   busy, grant_loc          status: not idle; source of last issued command (1 = local)
//   timeout_err, host_ovf    sticky error flags
module ad9866_cmd_arb #(
    parameter int TIMEOUT = 4096,
    parameter int GAP     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  host_addr,
    input  logic [31:0] host_data,
    input  logic        host_rqst,
    input  logic [5:0]  loc_addr,
    input  logic [31:0] loc_data,
    input  logic        loc_valid,
    output logic        loc_ready,
    output logic [5:0]  out_addr,
    output logic [31:0] out_data,
    output logic        out_rqst,
    input  logic        in_ack,
    input  logic        clr_status,
    output logic        busy,
    output logic        grant_loc,
    output logic        timeout_err,
    output logic        host_ovf
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_GAP      = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic          host_pend_q, host_pend_d;
    logic [5:0]    host_addr_q, host_addr_d;
    logic [31:0]   host_data_q, host_data_d;
    logic          loc_pend_q, loc_pend_d;
    logic [5:0]    loc_addr_q, loc_addr_d;
    logic [31:0]   loc_data_q, loc_data_d;
    logic [5:0]    out_addr_q, out_addr_d;
    logic [31:0]   out_data_q, out_data_d;
    logic          grant_loc_q, grant_loc_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [7:0]    gap_cnt_q, gap_cnt_d;
    logic          timeout_err_q, timeout_err_d;
    logic          host_ovf_q, host_ovf_d;

    logic          grant_h;
    logic          grant_l;
    logic          tmo_evt;
    logic          ovf_evt;
    logic          loc_take;

    assign loc_ready   = !loc_pend_q;
    assign loc_take    = loc_valid && !loc_pend_q;
    assign out_rqst    = (state_q == S_ISSUE);
    assign busy        = (state_q != S_IDLE);
    assign out_addr    = out_addr_q;
    assign out_data    = out_data_q;
    assign grant_loc   = grant_loc_q;
    assign timeout_err = timeout_err_q;
    assign host_ovf    = host_ovf_q;

    always_comb begin
        state_d       = state_q;
        out_addr_d    = out_addr_q;
        out_data_d    = out_data_q;
        grant_loc_d   = grant_loc_q;
        tmo_cnt_d     = tmo_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        grant_h       = 1'b0;
        grant_l       = 1'b0;
        tmo_evt       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (host_pend_q || loc_pend_q) begin
                    // Round-robin on a tie: serve the source that did not go last.
                    if (loc_pend_q && (!host_pend_q || !grant_loc_q)) begin
                        grant_l     = 1'b1;
                        out_addr_d  = loc_addr_q;
                        out_data_d  = loc_data_q;
                        grant_loc_d = 1'b1;
                    end else begin
                        grant_h     = 1'b1;
                        out_addr_d  = host_addr_q;
                        out_data_d  = host_data_q;
                        grant_loc_d = 1'b0;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // An ack arriving on the terminal count still wins over the timeout.
                if (in_ack) begin
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
                    tmo_evt   = 1'b1;
                    gap_cnt_d = '0;
                    state_d   = S_GAP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 8'(GAP - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pending slots. A request arriving in the cycle its slot is granted is kept,
    // because the load takes priority over the clear.
    always_comb begin
        host_pend_d = host_pend_q;
        host_addr_d = host_addr_q;
        host_data_d = host_data_q;
        loc_pend_d  = loc_pend_q;
        loc_addr_d  = loc_addr_q;
        loc_data_d  = loc_data_q;
        ovf_evt     = 1'b0;

        if (grant_h) begin
            host_pend_d = 1'b0;
        end
        if (host_rqst) begin
            ovf_evt     = host_pend_q && !grant_h;
            host_pend_d = 1'b1;
            host_addr_d = host_addr;
            host_data_d = host_data;
        end

        if (grant_l) begin
            loc_pend_d = 1'b0;
        end
        if (loc_take) begin
            loc_pend_d = 1'b1;
            loc_addr_d = loc_addr;
            loc_data_d = loc_data;
        end
    end

    // Sticky flags: a set in the same cycle as clr_status wins.
    always_comb begin
        timeout_err_d = tmo_evt || (timeout_err_q && !clr_status);
        host_ovf_d    = ovf_evt || (host_ovf_q && !clr_status);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            host_pend_q   <= 1'b0;
            host_addr_q   <= '0;
            host_data_q   <= '0;
            loc_pend_q    <= 1'b0;
            loc_addr_q    <= '0;
            loc_data_q    <= '0;
            out_addr_q    <= '0;
            out_data_q    <= '0;
            grant_loc_q   <= 1'b1;
            tmo_cnt_q     <= '0;
            gap_cnt_q     <= '0;
            timeout_err_q <= 1'b0;
            host_ovf_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            host_pend_q   <= host_pend_d;
            host_addr_q   <= host_addr_d;
            host_data_q   <= host_data_d;
            loc_pend_q    <= loc_pend_d;
            loc_addr_q    <= loc_addr_d;
            loc_data_q    <= loc_data_d;
            out_addr_q    <= out_addr_d;
            out_data_q    <= out_data_d;
            grant_loc_q   <= grant_loc_d;
            tmo_cnt_q     <= tmo_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            timeout_err_q <= timeout_err_d;
            host_ovf_q    <= host_ovf_d;
        end
    end

endmodule

// File: tb/tb_ad9866_cmd_arb.sv
// Purpose : self-checking bench for ad9866_cmd_arb; a timestamp-based reference model
//           predicts issued commands (queued) and per-cycle status, a monitor compares.
// Latency : n/a.  Backpressure: bench honours loc_ready by holding loc_valid until accepted.
module tb_ad9866_cmd_arb;

    localparam int TIMEOUT = 16;
    localparam int GAP     = 3;

    logic        clk;
    logic        rst_n;
    logic [5:0]  host_addr;
    logic [31:0] host_data;
    logic        host_rqst;
    logic [5:0]  loc_addr;
    logic [31:0] loc_data;
    logic        loc_valid;
    logic        loc_ready;
    logic [5:0]  out_addr;
    logic [31:0] out_data;
    logic        out_rqst;
    logic        in_ack;
    logic        clr_status;
    logic        busy;
    logic        grant_loc;
    logic        timeout_err;
    logic        host_ovf;

    ad9866_cmd_arb #(.TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_addr(host_addr), .host_data(host_data), .host_rqst(host_rqst),
        .loc_addr(loc_addr), .loc_data(loc_data), .loc_valid(loc_valid), .loc_ready(loc_ready),
        .out_addr(out_addr), .out_data(out_data), .out_rqst(out_rqst),
        .in_ack(in_ack), .clr_status(clr_status),
        .busy(busy), .grant_loc(grant_loc), .timeout_err(timeout_err), .host_ovf(host_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          src;
        logic [5:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state (time-stamp arithmetic, not a state machine).
    int          cyc;
    bit          hp, lp, gl, te, ov;
    logic [5:0]  ha_m, la_m;
    logic [31:0] hd_m, ld_m;
    int          idle_from, ack_cycle, to_cycle, win_lo, win_hi;
    int          forced_d;
    bit          noise_en;
    bit          mon_en;
    bit          exp_busy, exp_lr, exp_gl, exp_te, exp_ov;

    // Local requester in the bench: holds its command until accepted.
    bit          loc_v;
    logic [5:0]  loc_a;
    logic [31:0] loc_d;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    task automatic model_reset();
        hp = 0; lp = 0; gl = 1; te = 0; ov = 0;
        ha_m = '0; la_m = '0; hd_m = '0; ld_m = '0;
        idle_from = 0; ack_cycle = -1; to_cycle = -1; win_lo = -1; win_hi = -2;
        forced_d = -1;
        exp_q.delete();
        loc_v = 0;
    endtask

    // One clock cycle: drive inputs for this cycle and advance the model.
    task automatic step(input bit hr, input logic [5:0] ha, input logic [31:0] hd, input bit clr);
        bit          s, ack, te_set, ov_set, acc;
        int          r, d;
        exp_t        e;
        @(posedge clk);
        #1;
        cyc++;
        exp_busy = (cyc < idle_from);
        exp_lr   = !lp;
        exp_gl   = gl;
        exp_te   = te;
        exp_ov   = ov;

        if (cyc >= idle_from && (hp || lp)) begin
            s = lp && (!hp || !gl);
            r = cyc + 1;
            e.cyc  = r;
            e.src  = s;
            e.addr = s ? la_m : ha_m;
            e.data = s ? ld_m : hd_m;
            exp_q.push_back(e);
            if (s) lp = 0; else hp = 0;
            gl = s;
            d = (forced_d >= 0) ? forced_d : int'($urandom_range(0, TIMEOUT + 2));
            forced_d = -1;
            win_lo = r + 1;
            if (d < TIMEOUT) begin
                ack_cycle = r + 1 + d;
                win_hi    = ack_cycle;
                to_cycle  = -1;
                idle_from = ack_cycle + GAP + 1;
            end else begin
                to_cycle  = r + TIMEOUT;
                win_hi    = to_cycle;
                ack_cycle = to_cycle + 1;      // late ack, must be ignored
                idle_from = to_cycle + GAP + 1;
            end
        end

        ack = (cyc == ack_cycle);
        if (noise_en && !(cyc >= win_lo && cyc <= win_hi) && ($urandom_range(0, 5) == 0))
            ack = 1;
        te_set = (cyc == to_cycle);

        ov_set = hr && hp;
        if (hr) begin
            hp = 1; ha_m = ha; hd_m = hd;
        end
        acc = loc_v && exp_lr;
        if (acc) begin
            lp = 1; la_m = loc_a; ld_m = loc_d;
        end
        te = te_set || (te && !clr);
        ov = ov_set || (ov && !clr);

        host_rqst  = hr;
        host_addr  = ha;
        host_data  = hd;
        loc_valid  = loc_v;
        loc_addr   = loc_a;
        loc_data   = loc_d;
        in_ack     = ack;
        clr_status = clr;
        mon_en     = 1;
        if (acc) loc_v = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 6'h3F, 32'hDEAD_BEEF, 0);
    endtask

    task automatic set_loc(input logic [5:0] a, input logic [31:0] d);
        loc_v = 1; loc_a = a; loc_d = d;
    endtask

    task automatic drive_idle_inputs();
        host_rqst = 0; host_addr = '0; host_data = '0;
        loc_valid = 0; loc_addr = '0; loc_data = '0;
        in_ack = 0; clr_status = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_rqst"},  64'(out_rqst),    64'd0);
        chk({tag, "_busy"},      64'(busy),        64'd0);
        chk({tag, "_out_addr"},  64'(out_addr),    64'd0);
        chk({tag, "_out_data"},  64'(out_data),    64'd0);
        chk({tag, "_grant_loc"}, 64'(grant_loc),   64'd1);
        chk({tag, "_tmo_err"},   64'(timeout_err), 64'd0);
        chk({tag, "_host_ovf"},  64'(host_ovf),    64'd0);
        chk({tag, "_loc_ready"}, 64'(loc_ready),   64'd1);
    endtask

    // Asynchronous reset asserted mid-cycle, outputs checked before any clock edge.
    task automatic do_reset(input string tag);
        @(posedge clk);
        mon_en = 0;
        #3;
        rst_n = 0;
        drive_idle_inputs();
        #1;
        check_reset_outputs(tag);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    // Monitor: compares issued commands against the expected queue and status every cycle.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("missing_out_rqst", 64'(cyc), 64'(exp_q[0].cyc));
                void'(exp_q.pop_front());
            end
            if (out_rqst) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_rqst", 64'(out_rqst), 64'd0);
                end else if (exp_q[0].cyc == cyc) begin
                    chk("cmd_addr", 64'(out_addr), 64'(exp_q[0].addr));
                    chk("cmd_data", 64'(out_data), 64'(exp_q[0].data));
                    chk("cmd_src",  64'(grant_loc), 64'(exp_q[0].src));
                    void'(exp_q.pop_front());
                end else begin
                    chk("out_rqst_cycle", 64'(cyc), 64'(exp_q[0].cyc));
                end
            end
            chk("busy",        64'(busy),        64'(exp_busy));
            chk("loc_ready",   64'(loc_ready),   64'(exp_lr));
            chk("grant_loc",   64'(grant_loc),   64'(exp_gl));
            chk("timeout_err", 64'(timeout_err), 64'(exp_te));
            chk("host_ovf",    64'(host_ovf),    64'(exp_ov));
        end
    end

    initial begin
        cyc = 0;
        mon_en = 0;
        noise_en = 0;
        rst_n = 0;
        drive_idle_inputs();
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst_n = 1;

        // Host only: ack 7 cycles into WAIT_ACK, busy drops GAP+1 cycles after the ack.
        idle(5);
        forced_d = 7;
        step(1, 6'h09, 32'h0000_0020, 0);
        idle(25);

        // Tie straight after reset: host first, then local, then host again on the next tie.
        do_reset("rst_tie");
        set_loc(6'h11, 32'hA5A5_0001);
        step(1, 6'h0A, 32'h0000_1234, 0);
        idle(50);
        set_loc(6'h12, 32'hA5A5_0002);
        step(1, 6'h0B, 32'h0000_5678, 0);
        idle(50);

        // Overflow: two host requests during WAIT_ACK, only the second is issued.
        forced_d = 12;
        step(1, 6'h01, 32'h0000_0001, 0);
        idle(4);
        step(1, 6'h02, 32'h0000_0002, 0);
        idle(1);
        step(1, 6'h03, 32'h0000_0003, 0);
        idle(40);
        step(0, 6'h00, 32'h0, 1);
        idle(3);
        // Overflow coinciding with clr_status: the set wins.
        forced_d = 12;
        step(1, 6'h04, 32'h0000_0004, 0);
        idle(4);
        step(1, 6'h05, 32'h0000_0005, 0);
        step(1, 6'h06, 32'h0000_0006, 1);
        idle(40);
        step(0, 6'h00, 32'h0, 1);

        // Timeout with a command waiting behind it, then ack exactly on the terminal count.
        forced_d = TIMEOUT + 1;
        step(1, 6'h21, 32'h0000_0021, 0);
        idle(3);
        step(1, 6'h22, 32'h0000_0022, 0);
        idle(50);
        step(0, 6'h00, 32'h0, 1);
        forced_d = TIMEOUT - 1;
        step(1, 6'h23, 32'h0000_0023, 0);
        idle(30);

        // Local backpressure: held requests are accepted one at a time and issued in order.
        set_loc(6'h31, 32'hC0DE_0001);
        idle(1);
        set_loc(6'h32, 32'hC0DE_0002);
        for (int k = 0; k < 60 && loc_v; k++) idle(1);
        set_loc(6'h33, 32'hC0DE_0003);
        for (int k = 0; k < 60 && loc_v; k++) idle(1);
        idle(60);

        // Reset while waiting for an ack with both slots full: nothing issued afterwards.
        forced_d = TIMEOUT + 1;
        step(1, 6'h2A, 32'h0000_002A, 0);
        idle(4);
        set_loc(6'h2B, 32'h0000_002B);
        step(1, 6'h2C, 32'h0000_002C, 0);
        idle(1);
        do_reset("rst_wait");
        idle(30);

        // Randomized traffic with stray acks outside the wait window.
        noise_en = 1;
        for (int i = 0; i < 1500; i++) begin
            if (!loc_v && $urandom_range(0, 4) == 0)
                set_loc(6'($urandom), $urandom);
            step($urandom_range(0, 5) == 0, 6'($urandom), $urandom, $urandom_range(0, 19) == 0);
        end
        noise_en = 0;
        idle(80);
        chk("all_cmds_issued", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
